// File: rtl/inst_fetch_if.sv
// Bundles the ROM fetch port and the ID-stage valid/ready port of the fetch unit.
// master = fetch unit, slave = ROM/ID/CTRL side.
interface inst_fetch_if;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_addr_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  modport master (
    output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
    input  rom_inst_i, branch_flag_i, branch_target_addr_i, flush_i, new_pc_i, id_ready_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
    output rom_inst_i, branch_flag_i, branch_target_addr_i, flush_i, new_pc_i, id_ready_i
  );
endinterface

// File: rtl/inst_fetch.sv
// OpenMIPS instruction fetch: owns the PC, fetches from a combinational ROM and
// buffers {pc, inst} pairs in a small prefetch FIFO towards the ID stage.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      pc_q;
  logic             run_q;
  logic [31:0]      fifo_pc   [FIFO_DEPTH];
  logic [31:0]      fifo_inst [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic        valid;
  logic        pop;
  logic        push;
  logic        redirect;
  logic        not_full;
  logic [31:0] redirect_pc;

  // A fetch may proceed into a full FIFO when the head leaves in the same cycle.
  always_comb begin
    redirect    = bus.flush_i | bus.branch_flag_i;
    redirect_pc = bus.flush_i ? {bus.new_pc_i[31:2], 2'b00}
                              : {bus.branch_target_addr_i[31:2], 2'b00};
    not_full    = count < CNT_W'(FIFO_DEPTH);
    valid       = count != '0;
    pop         = valid & bus.id_ready_i;
    push        = run_q & ~redirect & (not_full | pop);

    bus.rom_ce_o   = push;
    bus.rom_addr_o = pc_q;
    bus.id_valid_o = valid;
    bus.id_pc_o    = valid ? fifo_pc[rd_ptr]   : 32'h0;
    bus.id_inst_o  = valid ? fifo_inst[rd_ptr] : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= {RESET_PC[31:2], 2'b00};
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (redirect) begin
        pc_q <= redirect_pc;
      end else if (push) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  // A redirect kills everything buffered, including a head popped that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= 32'h0;
        fifo_inst[i] <= 32'h0;
      end
    end else if (push) begin
      fifo_pc[wr_ptr]   <= pc_q;
      fifo_inst[wr_ptr] <= bus.rom_inst_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a queue-based reference model tracks the
// fetch unit cycle by cycle under directed and random stimulus.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC_A = 32'h0000_0000;
  localparam int          DEPTH_A    = 2;
  localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_if bus_a ();
  inst_fetch_if bus_b ();

  inst_fetch #(.RESET_PC(RESET_PC_A), .FIFO_DEPTH(DEPTH_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  inst_fetch #(.RESET_PC(RESET_PC_B), .FIFO_DEPTH(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  // ROM returns zero whenever it is not enabled.
  assign bus_a.rom_inst_i = bus_a.rom_ce_o ? rom_word(bus_a.rom_addr_o) : 32'h0;
  assign bus_b.rom_inst_i = bus_b.rom_ce_o ? rom_word(bus_b.rom_addr_o) : 32'h0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [63:0] mq[$];
  logic [31:0] m_pc;
  bit          m_run;
  logic [97:0] exp_vec;
  bit          cur_ready, cur_br, cur_fl;
  logic [31:0] cur_tgt, cur_npc;

  function automatic logic [97:0] obs_a();
    return {bus_a.rom_ce_o, bus_a.rom_addr_o, bus_a.id_valid_o, bus_a.id_pc_o, bus_a.id_inst_o};
  endfunction

  function automatic logic [97:0] obs_b();
    return {bus_b.rom_ce_o, bus_b.rom_addr_o, bus_b.id_valid_o, bus_b.id_pc_o, bus_b.id_inst_o};
  endfunction

  task automatic m_reset();
    mq.delete();
    m_pc  = {RESET_PC_A[31:2], 2'b00};
    m_run = 1'b0;
  endtask

  // Drive one cycle of inputs (called just after a falling edge), then form the expected outputs.
  task automatic apply(input bit ready, input bit br, input logic [31:0] tgt,
                       input bit fl, input logic [31:0] npc);
    bit          v, pop, ce;
    logic [31:0] hp, hi;
    cur_ready = ready; cur_br = br; cur_tgt = tgt; cur_fl = fl; cur_npc = npc;
    bus_a.id_ready_i           = ready;
    bus_a.branch_flag_i        = br;
    bus_a.branch_target_addr_i = tgt;
    bus_a.flush_i              = fl;
    bus_a.new_pc_i             = npc;
    #1;
    v   = mq.size() != 0;
    hp  = v ? mq[0][63:32] : 32'h0;
    hi  = v ? mq[0][31:0]  : 32'h0;
    pop = v && ready;
    ce  = m_run && !(br || fl) && ((mq.size() < DEPTH_A) || pop);
    exp_vec = {ce, m_pc, v, hp, hi};
  endtask

  // Advance the model across the rising edge, then move to the next falling edge.
  task automatic commit();
    bit v, pop, ce;
    v   = mq.size() != 0;
    pop = v && cur_ready;
    ce  = exp_vec[97];
    if (rst) begin
      if (cur_fl) begin
        mq.delete();
        m_pc = {cur_npc[31:2], 2'b00};
      end else if (cur_br) begin
        mq.delete();
        m_pc = {cur_tgt[31:2], 2'b00};
      end else begin
        if (pop) void'(mq.pop_front());
        if (ce) begin
          mq.push_back({m_pc, rom_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
      m_run = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] seen_pc[$];
    logic [31:0] seen_inst[$];
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (obs_a() !== {1'b0, RESET_PC_A, 1'b0, 64'h0}) begin
        n_fail++;
        $display("[TB] FAIL reset_a cyc %0d: got %h want %h", i, obs_a(), {1'b0, RESET_PC_A, 1'b0, 64'h0});
      end
      n_cmp++;
      if (obs_b() !== {1'b0, RESET_PC_B, 1'b0, 64'h0}) begin
        n_fail++;
        $display("[TB] FAIL reset_b cyc %0d: got %h want %h", i, obs_b(), {1'b0, RESET_PC_B, 1'b0, 64'h0});
      end
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      n_cmp++;
      if (obs_a() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL startup cyc %0d: got %h want %h", i, obs_a(), exp_vec);
      end
      if (i == 0 || i == 1) begin
        n_cmp++;
        if (bus_a.rom_ce_o !== (i == 1)) begin
          n_fail++;
          $display("[TB] FAIL ce_rise cyc %0d: got %b want %b", i, bus_a.rom_ce_o, (i == 1));
        end
      end
      if (bus_a.id_valid_o === 1'b1) begin
        seen_pc.push_back(bus_a.id_pc_o);
        seen_inst.push_back(bus_a.id_inst_o);
      end
      commit();
    end
    n_cmp++;
    if (seen_pc.size() < 4) begin
      n_fail++;
      $display("[TB] FAIL startup_count: got %0d want >=4", seen_pc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if ({seen_pc[k], seen_inst[k]} !== {32'(4 * k), 32'h1000_0000 + 32'(k)}) begin
          n_fail++;
          $display("[TB] FAIL startup_seq %0d: got %h/%h want %h/%h", k, seen_pc[k], seen_inst[k],
                   32'(4 * k), 32'h1000_0000 + 32'(k));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] frozen_addr;
    logic [31:0] last_pc;
    bit          have_last;
    frozen_addr = 32'h0;
    have_last   = 1'b0;
    last_pc     = 32'h0;
    for (int i = 0; i < 12; i++) begin
      apply(i >= 6, 1'b0, 32'h0, 1'b0, 32'h0);
      n_cmp++;
      if (obs_a() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL backpressure cyc %0d: got %h want %h", i, obs_a(), exp_vec);
      end
      if (i == 3) frozen_addr = bus_a.rom_addr_o;
      if (i == 5) begin
        n_cmp++;
        if ({bus_a.rom_ce_o, bus_a.rom_addr_o} !== {1'b0, frozen_addr}) begin
          n_fail++;
          $display("[TB] FAIL stall_freeze: got ce=%b addr=%h want ce=0 addr=%h",
                   bus_a.rom_ce_o, bus_a.rom_addr_o, frozen_addr);
        end
      end
      if (i >= 6 && bus_a.id_valid_o === 1'b1) begin
        if (have_last) begin
          n_cmp++;
          if (bus_a.id_pc_o !== last_pc + 32'd4) begin
            n_fail++;
            $display("[TB] FAIL resume_order cyc %0d: got %h want %h", i, bus_a.id_pc_o, last_pc + 32'd4);
          end
        end
        have_last = 1'b1;
        last_pc   = bus_a.id_pc_o;
      end
      commit();
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      commit();
    end
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, i == 0, 32'h0000_0043, 1'b0, 32'h0);
      n_cmp++;
      if (obs_a() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL branch cyc %0d: got %h want %h", i, obs_a(), exp_vec);
      end
      if (i == 1) begin
        n_cmp++;
        if ({bus_a.rom_ce_o, bus_a.rom_addr_o, bus_a.id_valid_o} !== {1'b1, 32'h0000_0040, 1'b0}) begin
          n_fail++;
          $display("[TB] FAIL branch_target: got ce=%b addr=%h valid=%b want 1/00000040/0",
                   bus_a.rom_ce_o, bus_a.rom_addr_o, bus_a.id_valid_o);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if ({bus_a.id_valid_o, bus_a.id_pc_o} !== {1'b1, 32'h0000_0040}) begin
          n_fail++;
          $display("[TB] FAIL branch_head: got valid=%b pc=%h want 1/00000040",
                   bus_a.id_valid_o, bus_a.id_pc_o);
        end
      end
      commit();
    end
  endtask

  task automatic test_flush_priority();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, i == 1, 32'h0000_0200, i == 1, 32'h0000_0180);
      n_cmp++;
      if (obs_a() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL flush cyc %0d: got %h want %h", i, obs_a(), exp_vec);
      end
      if (i == 2) begin
        n_cmp++;
        if (bus_a.rom_addr_o !== 32'h0000_0180) begin
          n_fail++;
          $display("[TB] FAIL flush_priority: got %h want 00000180", bus_a.rom_addr_o);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if (bus_a.id_pc_o !== 32'h0000_0180) begin
          n_fail++;
          $display("[TB] FAIL flush_head: got %h want 00000180", bus_a.id_pc_o);
        end
      end
      commit();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom,
            $urandom_range(0, 29) == 0, $urandom);
      n_cmp++;
      if (obs_a() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL random cyc %0d: got %h want %h", i, obs_a(), exp_vec);
      end
      commit();
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 6; i++) begin
      apply(i < 3, 1'b0, 32'h0, 1'b0, 32'h0);
      commit();
    end
    n_cmp++;
    if (bus_a.id_valid_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_valid: got %b want 1", bus_a.id_valid_o);
    end
    rst = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if (obs_a() !== {1'b0, RESET_PC_A, 1'b0, 64'h0}) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: got %h want %h", obs_a(), {1'b0, RESET_PC_A, 1'b0, 64'h0});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      n_cmp++;
      if (obs_a() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL restart cyc %0d: got %h want %h", i, obs_a(), exp_vec);
      end
      if (i == 2) begin
        n_cmp++;
        if ({bus_a.id_valid_o, bus_a.id_pc_o} !== {1'b1, RESET_PC_A}) begin
          n_fail++;
          $display("[TB] FAIL restart_head: got valid=%b pc=%h want 1/%h",
                   bus_a.id_valid_o, bus_a.id_pc_o, RESET_PC_A);
        end
      end
      commit();
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] seen_pc[$];
    logic [31:0] seen_inst[$];
    logic [31:0] want_pc;
    rst = 1'b0;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      n_cmp++;
      if (obs_a() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL wrap_a cyc %0d: got %h want %h", i, obs_a(), exp_vec);
      end
      if (bus_b.id_valid_o === 1'b1) begin
        seen_pc.push_back(bus_b.id_pc_o);
        seen_inst.push_back(bus_b.id_inst_o);
      end
      commit();
    end
    n_cmp++;
    if (seen_pc.size() < 3) begin
      n_fail++;
      $display("[TB] FAIL wrap_count: got %0d want >=3", seen_pc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        want_pc = RESET_PC_B + 32'(4 * k);
        n_cmp++;
        if ({seen_pc[k], seen_inst[k]} !== {want_pc, 32'h1000_0000 + (want_pc >> 2)}) begin
          n_fail++;
          $display("[TB] FAIL wrap_seq %0d: got %h/%h want %h/%h", k, seen_pc[k], seen_inst[k],
                   want_pc, 32'h1000_0000 + (want_pc >> 2));
        end
      end
    end
  endtask

  initial begin
    rst                        = 1'b0;
    bus_a.id_ready_i           = 1'b0;
    bus_a.branch_flag_i        = 1'b0;
    bus_a.branch_target_addr_i = 32'h0;
    bus_a.flush_i              = 1'b0;
    bus_a.new_pc_i             = 32'h0;
    bus_b.id_ready_i           = 1'b1;
    bus_b.branch_flag_i        = 1'b0;
    bus_b.branch_target_addr_i = 32'h0;
    bus_b.flush_i              = 1'b0;
    bus_b.new_pc_i             = 32'h0;
    @(negedge clk);
    test_reset();
    test_backpressure();
    test_branch();
    test_flush_priority();
    test_random();
    test_mid_reset();
    test_pc_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
